// File: rtl/lcd_msg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_msg_sequencer : plays one of N_MSGS ROM messages to the LCD_Controller |
// |   Avalon-MM slave; a next_msg pulse advances the selection and replays.   |
// | Optional macro: LCD_GAP_EN (idle GAP_CYCLES after every transfer).        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

package lcd_inst_pkg;
  localparam logic [8:0] CLEAR_DISPLAY = 9'h001;
  localparam logic [8:0] RETURN_HOME   = 9'h002;

  // Data writes go to Avalon address 1.
  function automatic logic [8:0] lcd_char(input logic [7:0] c);
    return {1'b1, c};
  endfunction
endpackage

module lcd_msg_sequencer
  import lcd_inst_pkg::*;
#(
  parameter int N_MSGS  = 4,
  parameter int MSG_LEN = 9,
  // Word k = message k/MSG_LEN, instruction k%MSG_LEN, stored at bits [9k +: 9].
  parameter logic [N_MSGS*MSG_LEN*9-1:0] MSG_ROM = {
    lcd_char("4"), lcd_char(" "), lcd_char("n"), lcd_char("o"), lcd_char("i"),
    lcd_char("t"), lcd_char("p"), lcd_char("o"), CLEAR_DISPLAY,
    lcd_char("3"), lcd_char(" "), lcd_char("n"), lcd_char("o"), lcd_char("i"),
    lcd_char("t"), lcd_char("p"), lcd_char("o"), CLEAR_DISPLAY,
    lcd_char("2"), lcd_char(" "), lcd_char("n"), lcd_char("o"), lcd_char("i"),
    lcd_char("t"), lcd_char("p"), lcd_char("o"), CLEAR_DISPLAY,
    lcd_char("1"), lcd_char(" "), lcd_char("n"), lcd_char("o"), lcd_char("i"),
    lcd_char("t"), lcd_char("p"), lcd_char("o"), CLEAR_DISPLAY
  },
  parameter int GAP_CYCLES = 4,
  localparam int SEL_W = (N_MSGS > 1) ? $clog2(N_MSGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next_msg,
  output logic             busy,
  output logic [SEL_W-1:0] msg_sel,
  output logic             address,
  output logic             chipselect,
  output logic             byteenable,
  output logic             read,
  output logic             write,
  input  logic             waitrequest,
  input  logic [7:0]       readdata,
  input  logic [1:0]       response,
  output logic [7:0]       writedata
);

  localparam int IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int N_WORDS = N_MSGS * MSG_LEN;
  localparam int ROM_AW  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

`ifdef LCD_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_NEXT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WRITE, S_NEXT} state_t;
`endif

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   msg_sel_q, msg_sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic               busy_q, busy_d;
`ifdef LCD_GAP_EN
  logic [GAP_W-1:0]   gap_q, gap_d;
`endif

  logic [8:0]         rom [N_WORDS];
  logic [ROM_AW-1:0]  rom_addr;
  logic [8:0]         rom_word;
  logic [SEL_W-1:0]   sel_next;
  logic               last_instr;
  logic               unused_ok;

  for (genvar g = 0; g < N_WORDS; g++) begin : g_rom
    assign rom[g] = MSG_ROM[g*9 +: 9];
  end

  assign rom_addr   = ROM_AW'(int'(msg_sel_q) * MSG_LEN + int'(idx_q));
  assign rom_word   = rom[rom_addr];
  assign sel_next   = (msg_sel_q == SEL_W'(N_MSGS - 1)) ? '0 : msg_sel_q + 1'b1;
  assign last_instr = (idx_q == IDX_W'(MSG_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_START;
      msg_sel_q <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LCD_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      msg_sel_q <= msg_sel_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
`ifdef LCD_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    msg_sel_d = msg_sel_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    busy_d    = busy_q;
`ifdef LCD_GAP_EN
    gap_d     = gap_q;
`endif
    // Any request while a message is in flight is remembered exactly once.
    if (next_msg && state_q != S_IDLE) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (next_msg) begin
          msg_sel_d = sel_next;
          state_d   = S_START;
        end
      end
      S_START: begin
        idx_d   = '0;
        busy_d  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!waitrequest) begin
`ifdef LCD_GAP_EN
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_NEXT : S_GAP;
`else
          state_d = S_NEXT;
`endif
        end
      end
`ifdef LCD_GAP_EN
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_NEXT;
        else gap_d = gap_q + 1'b1;
      end
`endif
      S_NEXT: begin
        if (last_instr) begin
          busy_d = 1'b0;
          // A request arriving in this very cycle still counts as pending.
          if (pending_q || next_msg) begin
            msg_sel_d = sel_next;
            pending_d = 1'b0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign write      = (state_q == S_WRITE);
  assign chipselect = write;
  assign address    = write & rom_word[8];
  assign writedata  = write ? rom_word[7:0] : 8'h00;
  assign byteenable = 1'b1;
  assign read       = 1'b0;
  assign busy       = busy_q;
  assign msg_sel    = msg_sel_q;

  assign unused_ok = ^{readdata, response, 32'(GAP_CYCLES)};

endmodule

`default_nettype wire

// File: tb/tb_lcd_msg_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised bench for lcd_msg_sequencer: transfers are captured off the bus
// and compared with message text built from the "option N" rules.
module tb_lcd_msg_sequencer;
  localparam int N_MSGS  = 4;
  localparam int MSG_LEN = 9;
`ifdef LCD_GAP_EN
  localparam int SPACING = 4 + 2;
`else
  localparam int SPACING = 2;
`endif

  logic       clk = 1'b0, reset = 1'b1, next_msg = 1'b0, waitrequest = 1'b0;
  logic [7:0] readdata = 8'hA5;
  logic [1:0] response = 2'b00;
  logic       busy, address, chipselect, byteenable, read, write;
  logic [1:0] msg_sel;
  logic [7:0] writedata;

  int checks = 0, errors = 0;
  int wr_mode = 0, stall_idx = 0, stall_max = 0, stall_run = 0;
  int cyc = 0, cur_wcyc = 0;
  int static_bad = 0, hold_bad = 0, gap_bad = 0;
  logic [8:0] xfers[$];
  int wcycs[$], rises[$];
  logic last_write = 1'b0, last_wait = 1'b0, last_addr = 1'b0;
  logic [7:0] last_data = 8'h00;
  int exp_sel = 0;

  lcd_msg_sequencer dut (
    .clk(clk), .reset(reset), .next_msg(next_msg), .busy(busy), .msg_sel(msg_sel),
    .address(address), .chipselect(chipselect), .byteenable(byteenable), .read(read),
    .write(write), .waitrequest(waitrequest), .readdata(readdata), .response(response),
    .writedata(writedata)
  );

  always #5 clk = ~clk;

  // Reference: message m is CLEAR_DISPLAY, then the text "option <m+1>".
  function automatic logic [8:0] exp_word(input int m, input int i);
    string s;
    s = "option ";
    if (i == 0) return 9'h001;
    if (i <= 7) return {1'b1, s[i-1]};
    return {1'b1, 8'(8'h31 + m)};
  endfunction

  // Slave model: 0 = never stall, 1 = random short stalls, 2 = stall one transfer.
  initial forever begin
    @(posedge clk); #2;
    case (wr_mode)
      0: waitrequest = 1'b0;
      1: begin
        waitrequest = (stall_run < 2) && ($urandom_range(0, 3) == 0);
        stall_run   = waitrequest ? stall_run + 1 : 0;
      end
      default: waitrequest = write && (xfers.size() == stall_idx) && (cur_wcyc < stall_max);
    endcase
  end

  // Bus observer: captures completed transfers and tallies protocol breaches.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      last_write = 1'b0;
      last_wait  = 1'b0;
      cur_wcyc   = 0;
    end else begin
      if (chipselect !== write || byteenable !== 1'b1 || read !== 1'b0 ||
          (!write && (writedata !== 8'h00 || address !== 1'b0)) || (write && busy !== 1'b1))
        static_bad++;
      if (last_write && last_wait && (write !== 1'b1 || address !== last_addr || writedata !== last_data))
        hold_bad++;
      if (last_write && !last_wait && write !== 1'b0)
        gap_bad++;
      if (write === 1'b1) begin
        cur_wcyc++;
        if (!last_write) rises.push_back(cyc);
        if (waitrequest === 1'b0) begin
          xfers.push_back({address, writedata});
          wcycs.push_back(cur_wcyc);
          cur_wcyc = 0;
        end
      end
      last_write = write;
      last_wait  = waitrequest;
      last_addr  = address;
      last_data  = writedata;
    end
  end

  task automatic cycle();
    @(posedge clk); #2;
  endtask

  task automatic pulse();
    next_msg = 1'b1;
    cycle();
    next_msg = 1'b0;
  endtask

  task automatic clear_log();
    xfers.delete();
    wcycs.delete();
    rises.delete();
  endtask

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (xfers.size() >= n) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    wr_mode = 0;
    repeat (3) cycle();
    checks++;
    if ({write, chipselect, address, busy, msg_sel, writedata} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs write=%b cs=%b addr=%b busy=%b sel=%0d wd=%h required all 0",
               write, chipselect, address, busy, msg_sel, writedata);
    end
    checks++;
    if (byteenable !== 1'b1 || read !== 1'b0) begin
      errors++;
      $display("FAIL reset_consts be=%b rd=%b required be=1 rd=0", byteenable, read);
    end
    clear_log();
    reset = 1'b0;
    wait_xfers(9, 300, ok);
    repeat (20) cycle();
    checks++;
    if (!ok || xfers.size() != MSG_LEN) begin
      errors++;
      $display("FAIL boot_count transfers=%0d required %0d", xfers.size(), MSG_LEN);
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        checks++;
        if (xfers[i] !== exp_word(0, i)) begin
          errors++;
          $display("FAIL boot_word[%0d] got %h required %h", i, xfers[i], exp_word(0, i));
        end
        checks++;
        if (wcycs[i] != 1) begin
          errors++;
          $display("FAIL boot_strobe_len[%0d] got %0d required 1", i, wcycs[i]);
        end
      end
      for (int i = 0; i + 1 < rises.size(); i++) begin
        checks++;
        if (rises[i+1] - rises[i] != SPACING) begin
          errors++;
          $display("FAIL strobe_spacing[%0d] got %0d required %0d", i, rises[i+1] - rises[i], SPACING);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || msg_sel !== 2'd0) begin
      errors++;
      $display("FAIL boot_end busy=%b sel=%0d required busy=0 sel=0", busy, msg_sel);
    end
    exp_sel = 0;
  endtask

  task automatic test_cycle();
    wr_mode = 1;
    for (int k = 0; k < N_MSGS; k++) begin
      clear_log();
      pulse();
      exp_sel = (exp_sel + 1) % N_MSGS;
      repeat (100) cycle();
      checks++;
      if (xfers.size() != MSG_LEN) begin
        errors++;
        $display("FAIL cycle%0d_count transfers=%0d required %0d", k, xfers.size(), MSG_LEN);
      end else begin
        for (int i = 0; i < MSG_LEN; i++) begin
          checks++;
          if (xfers[i] !== exp_word(exp_sel, i)) begin
            errors++;
            $display("FAIL cycle%0d_word[%0d] got %h required %h", k, i, xfers[i], exp_word(exp_sel, i));
          end
        end
      end
      checks++;
      if (msg_sel !== 2'(exp_sel) || busy !== 1'b0) begin
        errors++;
        $display("FAIL cycle%0d_sel sel=%0d busy=%b required sel=%0d busy=0", k, msg_sel, busy, exp_sel);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    wr_mode   = 2;
    stall_idx = 2;
    stall_max = 5;
    clear_log();
    pulse();
    exp_sel = (exp_sel + 1) % N_MSGS;
    wait_xfers(9, 400, ok);
    repeat (30) cycle();
    checks++;
    if (xfers.size() != MSG_LEN) begin
      errors++;
      $display("FAIL stall_count transfers=%0d required %0d", xfers.size(), MSG_LEN);
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        checks++;
        if (xfers[i] !== exp_word(exp_sel, i)) begin
          errors++;
          $display("FAIL stall_word[%0d] got %h required %h", i, xfers[i], exp_word(exp_sel, i));
        end
      end
      checks++;
      if (wcycs[2] != 6) begin
        errors++;
        $display("FAIL stall_write_cycles got %0d required 6", wcycs[2]);
      end
    end
    checks++;
    if (msg_sel !== 2'(exp_sel)) begin
      errors++;
      $display("FAIL stall_sel got %0d required %0d", msg_sel, exp_sel);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int k;
    wr_mode = 1;
    reset = 1'b1;
    cycle();
    clear_log();
    reset = 1'b0;
    exp_sel = 0;
    k = $urandom_range(1, 3);
    wait_xfers(k, 200, ok);
    for (int p = 0; p < 3; p++) begin
      pulse();
      repeat ($urandom_range(0, 1)) cycle();
    end
    wait_xfers(2 * MSG_LEN, 600, ok);
    repeat (150) cycle();
    checks++;
    if (xfers.size() != 2 * MSG_LEN) begin
      errors++;
      $display("FAIL b2b_count transfers=%0d required %0d", xfers.size(), 2 * MSG_LEN);
    end else begin
      for (int i = 0; i < 2 * MSG_LEN; i++) begin
        checks++;
        if (xfers[i] !== exp_word(i / MSG_LEN, i % MSG_LEN)) begin
          errors++;
          $display("FAIL b2b_word[%0d] got %h required %h", i, xfers[i], exp_word(i / MSG_LEN, i % MSG_LEN));
        end
      end
    end
    exp_sel = 1;
    checks++;
    if (msg_sel !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sel sel=%0d busy=%b required sel=1 busy=0", msg_sel, busy);
    end
  endtask

  task automatic test_pulse_on_last();
    bit ok;
    bit hit;
    int first;
    wr_mode = 0;
    clear_log();
    pulse();
    exp_sel = (exp_sel + 1) % N_MSGS;
    first = exp_sel;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      cycle();
      if (write === 1'b1 && xfers.size() == MSG_LEN - 1) begin
        next_msg = 1'b1;
        cycle();
        next_msg = 1'b0;
        hit = 1'b1;
      end
    end
    exp_sel = (exp_sel + 1) % N_MSGS;
    wait_xfers(2 * MSG_LEN, 400, ok);
    repeat (150) cycle();
    checks++;
    if (!hit || xfers.size() != 2 * MSG_LEN) begin
      errors++;
      $display("FAIL last_pulse_count hit=%b transfers=%0d required hit=1 %0d", hit, xfers.size(), 2 * MSG_LEN);
    end else begin
      for (int i = 0; i < 2 * MSG_LEN; i++) begin
        checks++;
        if (xfers[i] !== exp_word((first + i / MSG_LEN) % N_MSGS, i % MSG_LEN)) begin
          errors++;
          $display("FAIL last_pulse_word[%0d] got %h required %h", i, xfers[i],
                   exp_word((first + i / MSG_LEN) % N_MSGS, i % MSG_LEN));
        end
      end
    end
    checks++;
    if (msg_sel !== 2'(exp_sel)) begin
      errors++;
      $display("FAIL last_pulse_sel got %0d required %0d", msg_sel, exp_sel);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    wr_mode   = 2;
    stall_idx = 4;
    stall_max = 1000;
    clear_log();
    pulse();
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      cycle();
      if (write === 1'b1 && xfers.size() == 4) hit = 1'b1;
    end
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (!hit || write !== 1'b0 || chipselect !== 1'b0 || writedata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_write hit=%b write=%b cs=%b wd=%h required hit=1 all 0",
               hit, write, chipselect, writedata);
    end
    cycle();
    clear_log();
    wr_mode = 0;
    reset = 1'b0;
    exp_sel = 0;
    wait_xfers(MSG_LEN, 300, ok);
    repeat (20) cycle();
    checks++;
    if (xfers.size() != MSG_LEN) begin
      errors++;
      $display("FAIL reset_mid_count transfers=%0d required %0d", xfers.size(), MSG_LEN);
    end else begin
      for (int i = 0; i < MSG_LEN; i++) begin
        checks++;
        if (xfers[i] !== exp_word(0, i)) begin
          errors++;
          $display("FAIL reset_mid_word[%0d] got %h required %h", i, xfers[i], exp_word(0, i));
        end
      end
    end
    checks++;
    if (msg_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_sel got %0d required 0", msg_sel);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (static_bad != 0 || hold_bad != 0 || gap_bad != 0) begin
      errors++;
      $display("FAIL protocol static=%0d hold=%0d strobe_gap=%0d required 0 0 0",
               static_bad, hold_bad, gap_bad);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_stall();
    test_back_to_back();
    test_pulse_on_last();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
